mem_responder: RTL and testbench
================================

# mem_responder

Bus responder that services the CPU core's memory requests (data read, data write, 32-bit instruction fetch) from a single-port synchronous SRAM. It sits between the core's external memory pins and the SRAM macro. It generates the busy/ready/cack handshake the core waits on and assembles 32-bit instruction words from two 16-bit SRAM reads.

## Interface
- WAIT_CYCLES, 1: extra wait-state cycles inserted before every SRAM access; legal range 0..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  20  CPU word address; sampled at accept.
- wdata  in  16  CPU write data; sampled at accept.
- rd  in  1  read request (core ram_read_out).
- wr  in  1  write request (core ram_write).
- instr  in  1  instruction access; with rd, selects a 32-bit fetch.
- rd_done  in  1  CPU has consumed the read data (core ram_read_done).
- rdata  out  16  data read result.
- instr_data  out  32  fetch result: {mem[A+1], mem[A]}.
- busy  out  1  request in progress.
- ready  out  1  read data valid (held) or write complete (pulse).
- cack  out  1  one-cycle command-accept pulse.
- sram_addr  out  20  SRAM word address.
- sram_wdata  out  16  SRAM write data.
- sram_re  out  1  SRAM read enable; data returns on sram_rdata the next cycle.
- sram_we  out  1  SRAM write enable.
- sram_rdata  in  16  SRAM read data.

## Operation
- All outputs are registered or Moore-decoded from state. Reset forces state IDLE, wait counter 0 and all outputs 0, including rdata and instr_data. SRAM enables deassert immediately on reset assertion.
- States:
  - IDLE: busy=0.
  - WAIT: busy=1.
  - RD0: sram_re=1, sram_addr=A.
  - RD1: sram_re=1, sram_addr=A+1. Captures sram_rdata into instr_data[15:0].
  - CAP: captures sram_rdata into rdata (data read) or instr_data[31:16] (fetch).
  - HOLD: ready=1.
  - WR: sram_we=1, sram_addr=A, sram_wdata=D.
  - WACK: ready=1.
- Accept happens only in IDLE, when rd or wr is high at an edge.
  - Latches A=addr, D=wdata, and the request type.
  - If rd and wr are both high, the write is performed and the read is ignored.
  - instr is meaningful only with rd.
  - cack=1 for the single cycle following the accept edge.
  - rd, wr and addr may change freely after accept.
- Accept transitions to WAIT with counter=WAIT_CYCLES-1, or directly to the access state if WAIT_CYCLES=0. WAIT exits when counter=0, otherwise decrements.
- Data read: RD0 -> CAP -> HOLD.
- Fetch: RD0 -> RD1 -> CAP -> HOLD.
- HOLD stays until rd_done=1 at an edge, then goes to IDLE. rdata and instr_data keep their values until the next read captures.
- Write: WR -> WACK -> IDLE.
- Requests while not in IDLE are ignored: no cack, no queueing. rd_done outside HOLD is ignored.
- A+1 wraps modulo 2^20: A=0xFFFFF reads its high half from 0x00000.

## Timing
Accept edge is E0; W=WAIT_CYCLES.
- busy rises at E0 and falls at the edge leaving HOLD or WACK.
- cack is high between E0 and E1.
- Data read: sram_re is high for the cycle after edge E0+W. ready rises at E0+W+2, and rdata is valid from the same edge.
- Fetch: sram_re is high for 2 cycles starting at edge E0+W. ready rises at E0+W+3.
- Write: sram_we is high for exactly 1 cycle starting at E0+W. ready pulses for 1 cycle starting at E0+W+1, then IDLE at E0+W+2.
- Back-to-back: the earliest next accept is the edge after the return to IDLE. The minimum gap is 1 idle cycle with busy=0.
- Reset mid-operation aborts the access without retry. A write in progress may or may not have reached the SRAM.

## Test plan
- Reset: hold rst=0 mid-fetch, then release -> all outputs 0, busy=0, next rd is accepted normally.
- Data read, W=1: preload mem[0x01234]=0xBEEF, pulse rd with addr=0x01234 -> cack high 1 cycle after E0, ready at E0+3, rdata=0xBEEF held until rd_done, then busy=0.
- Fetch, W=0: mem[0x00010]=0x1111, mem[0x00011]=0x2222, rd+instr -> ready at E0+3, instr_data=0x22221111. Repeat at A=0xFFFFF with mem[0]=0x3333 -> high half=0x3333.
- Write, W=2: wr with addr=0x00042, wdata=0xA5A5 -> sram_we for 1 cycle starting at E0+2, ready pulse at E0+3, then a read of 0x00042 returns 0xA5A5.
- Simultaneous rd+wr: write done and no read phase. A second rd asserted during busy -> no cack and no access.
- Sweep W=0..15 on data read -> ready latency = W+2 edges each time.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: services core data reads, writes and 32-bit fetches from a
// single-port synchronous SRAM with configurable wait states.
module mem_responder #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] addr,
    input  logic [15:0] wdata,
    input  logic        rd,
    input  logic        wr,
    input  logic        instr,
    input  logic        rd_done,
    output logic [15:0] rdata,
    output logic [31:0] instr_data,
    output logic        busy,
    output logic        ready,
    output logic        cack,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_re,
    output logic        sram_we,
    input  logic [15:0] sram_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD0, S_RD1, S_CAP, S_HOLD, S_WR, S_WACK} state_t;

    localparam int         W_INIT   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] CNT_INIT = 4'(W_INIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic        is_wr_q, is_wr_d;
    logic        is_fetch_q, is_fetch_d;
    logic        cack_q, cack_d;
    logic [15:0] rdata_q, rdata_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        d_d        = d_q;
        is_wr_d    = is_wr_q;
        is_fetch_d = is_fetch_q;
        cack_d     = 1'b0;
        rdata_d    = rdata_q;
        instr_d    = instr_q;
        case (state_q)
            S_IDLE: if (rd || wr) begin
                // write wins when rd and wr arrive together
                a_d        = addr;
                d_d        = wdata;
                is_wr_d    = wr;
                is_fetch_d = !wr && instr;
                cack_d     = 1'b1;
                cnt_d      = CNT_INIT;
                state_d    = (WAIT_CYCLES == 0) ? (wr ? S_WR : S_RD0) : S_WAIT;
            end
            S_WAIT: if (cnt_q == 4'd0) state_d = is_wr_q ? S_WR : S_RD0;
                    else cnt_d = cnt_q - 4'd1;
            S_RD0:  state_d = is_fetch_q ? S_RD1 : S_CAP;
            S_RD1: begin
                instr_d[15:0] = sram_rdata;
                state_d       = S_CAP;
            end
            S_CAP: begin
                if (is_fetch_q) instr_d[31:16] = sram_rdata;
                else rdata_d = sram_rdata;
                state_d = S_HOLD;
            end
            S_HOLD: if (rd_done) state_d = S_IDLE;
            S_WR:   state_d = S_WACK;
            S_WACK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            a_q        <= 20'd0;
            d_q        <= 16'd0;
            is_wr_q    <= 1'b0;
            is_fetch_q <= 1'b0;
            cack_q     <= 1'b0;
            rdata_q    <= 16'd0;
            instr_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            d_q        <= d_d;
            is_wr_q    <= is_wr_d;
            is_fetch_q <= is_fetch_d;
            cack_q     <= cack_d;
            rdata_q    <= rdata_d;
            instr_q    <= instr_d;
        end
    end

    // high half of a fetch comes from A+1, wrapping at the top of the address space
    assign sram_addr  = (state_q == S_RD1) ? a_q + 20'd1 : a_q;
    assign sram_wdata = d_q;
    assign sram_re    = (state_q == S_RD0) || (state_q == S_RD1);
    assign sram_we    = state_q == S_WR;
    assign busy       = state_q != S_IDLE;
    assign ready      = (state_q == S_HOLD) || (state_q == S_WACK);
    assign cack       = cack_q;
    assign rdata      = rdata_q;
    assign instr_data = instr_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder for every WAIT_CYCLES
// value 0..15, all instances sharing stimulus and one SRAM model.
module tb_mem_responder;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        rd = 1'b0, wr = 1'b0, instr = 1'b0, rd_done = 1'b0;

    logic [15:0] rdata_a  [N];
    logic [31:0] instr_a  [N];
    logic        busy_a   [N];
    logic        ready_a  [N];
    logic        cack_a   [N];
    logic [19:0] saddr_a  [N];
    logic [15:0] swdata_a [N];
    logic        re_a     [N];
    logic        we_a     [N];
    logic [15:0] srdata_a [N];

    logic [15:0] mem [0:1048575];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_responder #(.WAIT_CYCLES(g)) u_dut (
            .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
            .rd(rd), .wr(wr), .instr(instr), .rd_done(rd_done),
            .rdata(rdata_a[g]), .instr_data(instr_a[g]),
            .busy(busy_a[g]), .ready(ready_a[g]), .cack(cack_a[g]),
            .sram_addr(saddr_a[g]), .sram_wdata(swdata_a[g]),
            .sram_re(re_a[g]), .sram_we(we_a[g]), .sram_rdata(srdata_a[g])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++)
            if (re_a[k]) srdata_a[k] <= mem[saddr_a[k]];
        for (int k = 0; k < N; k++)
            if (we_a[k]) mem[saddr_a[k]] = swdata_a[k];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit any_busy();
        bit b = 1'b0;
        for (int k = 0; k < N; k++) b |= busy_a[k];
        return b;
    endfunction

    task automatic settle();
        int n = 0;
        rd_done = 1'b1;
        while (any_busy() && n < 40) begin
            step();
            n++;
        end
        rd_done = 1'b0;
        total++;
        if (any_busy()) begin
            bad++;
            $display("FAIL settle: busy=1 after %0d cycles, required 0", n);
        end
        step();
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            total++;
            if ({busy_a[k], ready_a[k], cack_a[k], re_a[k], we_a[k]} !== 5'b0 ||
                rdata_a[k] !== 16'h0 || instr_a[k] !== 32'h0 || saddr_a[k] !== 20'h0) begin
                bad++;
                $display("FAIL reset_init[%0d]: busy=%b ready=%b cack=%b re=%b we=%b rdata=%h instr=%h, required all 0",
                         k, busy_a[k], ready_a[k], cack_a[k], re_a[k], we_a[k], rdata_a[k], instr_a[k]);
            end
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_read();
        mem[20'h01234] = 16'hBEEF;
        addr = 20'h01234; rd = 1'b1;
        step();
        rd = 1'b0; addr = 20'h0ABCD;
        total++;
        if (cack_a[1] !== 1'b1 || busy_a[1] !== 1'b1) begin
            bad++; $display("FAIL read_cack: cack=%b busy=%b, required 1 1", cack_a[1], busy_a[1]);
        end
        step();
        total++;
        if (cack_a[1] !== 1'b0 || re_a[1] !== 1'b1 || saddr_a[1] !== 20'h01234) begin
            bad++; $display("FAIL read_re: cack=%b re=%b saddr=%h, required 0 1 01234", cack_a[1], re_a[1], saddr_a[1]);
        end
        step();
        total++;
        if (ready_a[1] !== 1'b0 || re_a[1] !== 1'b0) begin
            bad++; $display("FAIL read_early: ready=%b re=%b, required 0 0", ready_a[1], re_a[1]);
        end
        step();
        total++;
        if (ready_a[1] !== 1'b1 || rdata_a[1] !== 16'hBEEF) begin
            bad++; $display("FAIL read_ready: ready=%b rdata=%h, required 1 beef", ready_a[1], rdata_a[1]);
        end
        step(); step();
        total++;
        if (ready_a[1] !== 1'b1 || busy_a[1] !== 1'b1 || rdata_a[1] !== 16'hBEEF) begin
            bad++; $display("FAIL read_hold: ready=%b busy=%b rdata=%h, required 1 1 beef", ready_a[1], busy_a[1], rdata_a[1]);
        end
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        total++;
        if (busy_a[1] !== 1'b0 || ready_a[1] !== 1'b0 || rdata_a[1] !== 16'hBEEF) begin
            bad++; $display("FAIL read_done: busy=%b ready=%b rdata=%h, required 0 0 beef", busy_a[1], ready_a[1], rdata_a[1]);
        end
        settle();
    endtask

    task automatic test_fetch();
        mem[20'h00010] = 16'h1111;
        mem[20'h00011] = 16'h2222;
        addr = 20'h00010; rd = 1'b1; instr = 1'b1;
        step();
        rd = 1'b0; instr = 1'b0; addr = 20'h0;
        total++;
        if (re_a[0] !== 1'b1 || saddr_a[0] !== 20'h00010) begin
            bad++; $display("FAIL fetch_rd0: re=%b saddr=%h, required 1 00010", re_a[0], saddr_a[0]);
        end
        step();
        total++;
        if (re_a[0] !== 1'b1 || saddr_a[0] !== 20'h00011) begin
            bad++; $display("FAIL fetch_rd1: re=%b saddr=%h, required 1 00011", re_a[0], saddr_a[0]);
        end
        step();
        total++;
        if (ready_a[0] !== 1'b0 || re_a[0] !== 1'b0) begin
            bad++; $display("FAIL fetch_cap: ready=%b re=%b, required 0 0", ready_a[0], re_a[0]);
        end
        step();
        total++;
        if (ready_a[0] !== 1'b1 || instr_a[0] !== 32'h22221111) begin
            bad++; $display("FAIL fetch_data: ready=%b instr=%h, required 1 22221111", ready_a[0], instr_a[0]);
        end
        settle();
        mem[20'hFFFFF] = 16'h4444;
        mem[20'h00000] = 16'h3333;
        addr = 20'hFFFFF; rd = 1'b1; instr = 1'b1;
        step();
        rd = 1'b0; instr = 1'b0;
        step();
        total++;
        if (re_a[0] !== 1'b1 || saddr_a[0] !== 20'h00000) begin
            bad++; $display("FAIL fetch_wrap_addr: re=%b saddr=%h, required 1 00000", re_a[0], saddr_a[0]);
        end
        step(); step();
        total++;
        if (ready_a[0] !== 1'b1 || instr_a[0] !== 32'h33334444) begin
            bad++; $display("FAIL fetch_wrap_data: ready=%b instr=%h, required 1 33334444", ready_a[0], instr_a[0]);
        end
        settle();
    endtask

    task automatic test_write();
        mem[20'h00042] = 16'h0000;
        addr = 20'h00042; wdata = 16'hA5A5; wr = 1'b1;
        step();
        wr = 1'b0; wdata = 16'h0; addr = 20'h0;
        total++;
        if (we_a[2] !== 1'b0 || cack_a[2] !== 1'b1) begin
            bad++; $display("FAIL write_e0: we=%b cack=%b, required 0 1", we_a[2], cack_a[2]);
        end
        step();
        total++;
        if (we_a[2] !== 1'b0) begin
            bad++; $display("FAIL write_e1: we=%b, required 0", we_a[2]);
        end
        step();
        total++;
        if (we_a[2] !== 1'b1 || saddr_a[2] !== 20'h00042 || swdata_a[2] !== 16'hA5A5 || ready_a[2] !== 1'b0) begin
            bad++; $display("FAIL write_we: we=%b saddr=%h swdata=%h ready=%b, required 1 00042 a5a5 0",
                            we_a[2], saddr_a[2], swdata_a[2], ready_a[2]);
        end
        step();
        total++;
        if (we_a[2] !== 1'b0 || ready_a[2] !== 1'b1 || busy_a[2] !== 1'b1) begin
            bad++; $display("FAIL write_ack: we=%b ready=%b busy=%b, required 0 1 1", we_a[2], ready_a[2], busy_a[2]);
        end
        step();
        total++;
        if (ready_a[2] !== 1'b0 || busy_a[2] !== 1'b0) begin
            bad++; $display("FAIL write_idle: ready=%b busy=%b, required 0 0", ready_a[2], busy_a[2]);
        end
        settle();
        addr = 20'h00042; rd = 1'b1;
        step();
        rd = 1'b0;
        repeat (4) step();
        total++;
        if (ready_a[2] !== 1'b1 || rdata_a[2] !== 16'hA5A5) begin
            bad++; $display("FAIL write_readback: ready=%b rdata=%h, required 1 a5a5", ready_a[2], rdata_a[2]);
        end
        settle();
    endtask

    task automatic test_rdwr();
        int n_re = 0, n_we = 0, n_cack = 0, n_rdy = 0;
        bit saw_99 = 1'b0;
        mem[20'h00077] = 16'h1357;
        addr = 20'h00077; wdata = 16'h2468; rd = 1'b1; wr = 1'b1;
        step();
        wr = 1'b0; addr = 20'h00099;
        total++;
        if (cack_a[1] !== 1'b1) begin
            bad++; $display("FAIL rdwr_cack: cack=%b, required 1", cack_a[1]);
        end
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 1) rd = 1'b0;
            n_re   += int'(re_a[1]);
            n_we   += int'(we_a[1]);
            n_cack += int'(cack_a[1]);
            n_rdy  += int'(ready_a[1]);
            if (saddr_a[1] == 20'h00099) saw_99 = 1'b1;
        end
        total++;
        if (n_re != 0 || n_we != 1 || n_cack != 0 || n_rdy != 1 || saw_99) begin
            bad++; $display("FAIL rdwr_phases: re=%0d we=%0d cack=%0d ready=%0d addr99=%0d, required 0 1 0 1 0",
                            n_re, n_we, n_cack, n_rdy, saw_99);
        end
        total++;
        if (rdata_a[1] !== 16'hA5A5) begin
            bad++; $display("FAIL rdwr_rdata: rdata=%h, required a5a5", rdata_a[1]);
        end
        settle();
        total++;
        if (mem[20'h00077] !== 16'h2468) begin
            bad++; $display("FAIL rdwr_mem: mem=%h, required 2468", mem[20'h00077]);
        end
    endtask

    task automatic test_sweep();
        int lat [N];
        for (int k = 0; k < N; k++) lat[k] = 0;
        mem[20'h00500] = 16'h5A5A;
        addr = 20'h00500; rd = 1'b1;
        step();
        rd = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            for (int k = 0; k < N; k++)
                if (ready_a[k] && lat[k] == 0) lat[k] = n;
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (lat[k] != k + 2 || rdata_a[k] !== 16'h5A5A) begin
                bad++; $display("FAIL sweep_w%0d: latency=%0d rdata=%h, required %0d 5a5a", k, lat[k], rdata_a[k], k + 2);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid();
        mem[20'h00200] = 16'hAAAA;
        mem[20'h00201] = 16'hBBBB;
        addr = 20'h00200; rd = 1'b1; instr = 1'b1;
        step();
        rd = 1'b0; instr = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if ({busy_a[k], ready_a[k], cack_a[k], re_a[k], we_a[k]} !== 5'b0 || saddr_a[k] !== 20'h0 ||
                swdata_a[k] !== 16'h0 || rdata_a[k] !== 16'h0 || instr_a[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset_mid[%0d]: busy=%b ready=%b cack=%b re=%b we=%b saddr=%h rdata=%h instr=%h, required all 0",
                         k, busy_a[k], ready_a[k], cack_a[k], re_a[k], we_a[k], saddr_a[k], rdata_a[k], instr_a[k]);
            end
        end
        step(); step();
        rst = 1'b1;
        step();
        addr = 20'h00200; rd = 1'b1;
        step();
        rd = 1'b0;
        total++;
        if (cack_a[1] !== 1'b1) begin
            bad++; $display("FAIL reset_next_cack: cack=%b, required 1", cack_a[1]);
        end
        repeat (3) step();
        total++;
        if (ready_a[1] !== 1'b1 || rdata_a[1] !== 16'hAAAA) begin
            bad++; $display("FAIL reset_next_read: ready=%b rdata=%h, required 1 aaaa", ready_a[1], rdata_a[1]);
        end
        settle();
    endtask

    initial begin
        repeat (3) step();
        test_reset();
        test_read();
        test_fetch();
        test_write();
        test_rdwr();
        test_sweep();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
